row_tap_buffer_9x9: RTL

Producer side of the 9-row tap interface consumed by the 9x9 median filter. It accepts a raster-order 8-bit pixel stream, buffers the last eight image rows in line memories, and for each incoming pixel emits the nine vertically aligned pixels of that column (`d0_o`..`d8_o`) with a `done_o` strobe. It sits between the pixel source and the median filter's `d*_i`/`done_i` inputs.

---
 rtl/row_tap_buffer_9x9.sv | 74 +++++++
 1 files changed

// File: rtl/row_tap_buffer_9x9.sv
// row_tap_buffer_9x9: eight line memories turning a raster pixel stream into nine vertical taps per column
module row_tap_buffer_9x9 #(
  parameter int ROWS = 11,
  parameter int COLS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_i,
  input  logic       valid_i,
  output logic [7:0] d0_o,
  output logic [7:0] d1_o,
  output logic [7:0] d2_o,
  output logic [7:0] d3_o,
  output logic [7:0] d4_o,
  output logic [7:0] d5_o,
  output logic [7:0] d6_o,
  output logic [7:0] d7_o,
  output logic [7:0] d8_o,
  output logic       done_o,
  output logic       frame_done_o
);
  localparam int CW = ($clog2(COLS) < 1) ? 1 : $clog2(COLS);
  localparam int RW = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    line_q [8][COLS];
  logic [7:0]    tap_q [9];
  logic          done_q, frame_done_q;
  logic          last_col, last_row;
  // Raster position of the pixel after the one currently being accepted
  always_comb begin
    last_col = col_q == CW'(COLS - 1);
    last_row = row_q == RW'(ROWS - 1);
    col_d    = last_col ? '0 : col_q + 1'b1;
    row_d    = !last_col ? row_q : (last_row ? '0 : row_q + 1'b1);
  end
  // Counters, tap registers and strobes; strobes only fire on an accepted pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      tap_q        <= '{default: '0};
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      done_q       <= valid_i && (row_q >= RW'(8));
      frame_done_q <= valid_i && last_col && last_row;
      if (valid_i) begin
        col_q    <= col_d;
        row_q    <= row_d;
        tap_q[0] <= pixel_i;
        for (int k = 1; k < 9; k++) tap_q[k] <= line_q[k-1][col_q];
      end
    end
  end
  // Line memory cascade: each column shifts down one line, reading old contents before the write
  always_ff @(posedge clk) begin
    if (rst && valid_i) begin
      line_q[0][col_q] <= pixel_i;
      for (int k = 1; k < 8; k++) line_q[k][col_q] <= line_q[k-1][col_q];
    end
  end
  assign d0_o         = tap_q[0];
  assign d1_o         = tap_q[1];
  assign d2_o         = tap_q[2];
  assign d3_o         = tap_q[3];
  assign d4_o         = tap_q[4];
  assign d5_o         = tap_q[5];
  assign d6_o         = tap_q[6];
  assign d7_o         = tap_q[7];
  assign d8_o         = tap_q[8];
  assign done_o       = done_q;
  assign frame_done_o = frame_done_q;
endmodule
